// File: rtl/counter_monitor.sv
// Passive observer for an enable-gated up-counter: rebuilds the expected count from
// the previous sample, locks onto the sequence, then flags, counts and reports deviations.
module counter_monitor #(
    parameter int WIDTH       = 4,
    parameter int ERR_W       = 8,
    parameter int SYNC_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clear,
    output logic             locked,
    output logic             mismatch,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap_pulse,
    output logic [WIDTH-1:0] expected
);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        TRACK
    } state_t;

    localparam logic [3:0] SYNC_N = 4'(SYNC_CYCLES);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] cnt_q;
    logic             en_q;
    logic [3:0]       match_cnt;
    logic [3:0]       match_cnt_nx;
    logic             match;
    logic             err_now;
    logic             wrap_now;

    assign expected = cnt_q + WIDTH'(en_q);
    assign match    = (count_in == expected);
    assign locked   = (state == TRACK);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx     = state;
        match_cnt_nx = match_cnt;
        err_now      = 1'b0;
        wrap_now     = 1'b0;
        case (state)
            IDLE: begin
                state_nx     = SYNC;
                match_cnt_nx = '0;
            end
            SYNC: begin
                // An unknown compare falls to the else branch: it never advances the lock.
                if (match) begin
                    if (match_cnt + 4'd1 == SYNC_N) begin
                        state_nx     = TRACK;
                        match_cnt_nx = '0;
                    end else begin
                        match_cnt_nx = match_cnt + 4'd1;
                    end
                end else begin
                    match_cnt_nx = '0;
                end
            end
            TRACK: begin
                if (match) begin
                    wrap_now = en_q && (cnt_q == '1) && (count_in == '0);
                end else begin
                    err_now      = 1'b1;
                    state_nx     = SYNC;
                    match_cnt_nx = '0;
                end
            end
            default: begin
                state_nx     = IDLE;
                match_cnt_nx = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            match_cnt  <= '0;
            mismatch   <= 1'b0;
            wrap_pulse <= 1'b0;
            err_flag   <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_nx;
            cnt_q      <= count_in;
            en_q       <= enable;
            match_cnt  <= match_cnt_nx;
            mismatch   <= err_now;
            wrap_pulse <= wrap_now;
            // A new error takes priority over a simultaneous clear.
            if (err_now) begin
                err_flag <= 1'b1;
                if (clear) begin
                    err_count <= ERR_W'(1);
                end else if (err_count != '1) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end else if (clear) begin
                err_flag  <= 1'b0;
                err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: two instances (wide and 2-bit error counters) driven in
// parallel and compared against a sample-by-sample behavioural model of the rules.
module tb_counter_monitor;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       clear;
    logic [3:0] count_in;

    logic       locked_a, mismatch_a, err_flag_a, wrap_a;
    logic [7:0] err_count_a;
    logic [3:0] expected_a;
    logic       locked_b, mismatch_b, err_flag_b, wrap_b;
    logic [1:0] err_count_b;
    logic [3:0] expected_b;

    int checks   = 0;
    int failures = 0;

    counter_monitor #(.WIDTH(WIDTH), .ERR_W(8), .SYNC_CYCLES(SYNC)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .count_in(count_in), .clear(clear),
        .locked(locked_a), .mismatch(mismatch_a), .err_flag(err_flag_a),
        .err_count(err_count_a), .wrap_pulse(wrap_a), .expected(expected_a)
    );

    counter_monitor #(.WIDTH(WIDTH), .ERR_W(2), .SYNC_CYCLES(SYNC)) u_sat (
        .clk(clk), .rst(rst), .enable(enable), .count_in(count_in), .clear(clear),
        .locked(locked_b), .mismatch(mismatch_b), .err_flag(err_flag_b),
        .err_count(err_count_b), .wrap_pulse(wrap_b), .expected(expected_b)
    );

    always #5 clk = ~clk;

    // Reference model: previous sample, run of good samples, lock flag, raw error total.
    bit m_seen, m_prev_e, m_locked, m_mm, m_wrap, m_flag;
    int m_prev_c, m_streak, m_errors;

    function automatic int m_expected();
        return (m_prev_c + int'(m_prev_e)) % 16;
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_reset();
        m_seen = 0; m_prev_e = 0; m_locked = 0; m_mm = 0; m_wrap = 0; m_flag = 0;
        m_prev_c = 0; m_streak = 0; m_errors = 0;
    endtask

    task automatic model_edge(input bit en, input int c, input bit clr);
        bit err;
        err = 0;
        m_wrap = 0;
        if (!m_seen) begin
            m_seen = 1;
        end else if (m_locked) begin
            if (c == m_expected()) m_wrap = m_prev_e && (m_prev_c == 15) && (c == 0);
            else begin err = 1; m_locked = 0; m_streak = 0; end
        end else if (c == m_expected()) begin
            m_streak++;
            if (m_streak >= SYNC) begin m_locked = 1; m_streak = 0; end
        end else begin
            m_streak = 0;
        end
        m_mm = err;
        if (err) begin
            m_flag = 1;
            m_errors = clr ? 1 : m_errors + 1;
        end else if (clr) begin
            m_flag = 0;
            m_errors = 0;
        end
        m_prev_c = c;
        m_prev_e = en;
    endtask

    task automatic tick(input bit en, input int c, input bit clr);
        enable   = en;
        count_in = 4'(c);
        clear    = clr;
        @(posedge clk);
        model_edge(en, c, clr);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; count_in = '0; clear = 1'b0;
        model_reset();
        #12;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({locked_a, mismatch_a, err_flag_a, wrap_a} !== 4'b0) begin failures++; $display("FAIL reset_flags_a got=%b exp=0000", {locked_a, mismatch_a, err_flag_a, wrap_a}); end
        checks++; if (err_count_a !== 8'd0) begin failures++; $display("FAIL reset_err_count_a got=%0d exp=0", err_count_a); end
        checks++; if (expected_a !== 4'd0) begin failures++; $display("FAIL reset_expected_a got=%0d exp=0", expected_a); end
        checks++; if ({locked_b, mismatch_b, err_flag_b, wrap_b, err_count_b} !== 6'b0) begin failures++; $display("FAIL reset_b got=%b exp=000000", {locked_b, mismatch_b, err_flag_b, wrap_b, err_count_b}); end
    endtask

    task automatic test_lock();
        tick(1, 0, 0);
        checks++; if (locked_a !== 1'b0) begin failures++; $display("FAIL lock_edge1 got=%0b exp=0", locked_a); end
        tick(1, 1, 0);
        checks++; if (locked_a !== 1'b0) begin failures++; $display("FAIL lock_edge2 got=%0b exp=0", locked_a); end
        tick(1, 2, 0);
        checks++; if (locked_a !== 1'b1) begin failures++; $display("FAIL lock_edge3 got=%0b exp=1", locked_a); end
        tick(1, 3, 0);
        checks++; if (locked_a !== m_locked || err_count_a !== 8'd0) begin failures++; $display("FAIL lock_err_count locked=%0b cnt=%0d exp=1,0", locked_a, err_count_a); end
    endtask

    task automatic test_hold();
        bit ens[4] = '{1, 0, 0, 1};
        foreach (ens[i]) begin
            tick(ens[i], m_expected(), 0);
            checks++; if (mismatch_a !== 1'b0 || locked_a !== 1'b1) begin failures++; $display("FAIL hold_%0d mismatch=%0b locked=%0b exp=0,1", i, mismatch_a, locked_a); end
            checks++; if (int'(expected_a) !== m_expected()) begin failures++; $display("FAIL hold_expected_%0d got=%0d exp=%0d", i, expected_a, m_expected()); end
        end
    endtask

    task automatic test_error();
        do_reset();
        for (int c = 0; c <= 5; c++) tick(1, c, 0);
        tick(1, 9, 0);
        checks++; if (mismatch_a !== 1'b1 || err_flag_a !== 1'b1 || locked_a !== 1'b0) begin failures++; $display("FAIL err_inject mm=%0b flag=%0b locked=%0b exp=1,1,0", mismatch_a, err_flag_a, locked_a); end
        checks++; if (err_count_a !== 8'd1 || err_count_b !== 2'd1) begin failures++; $display("FAIL err_count a=%0d b=%0d exp=1", err_count_a, err_count_b); end
        tick(1, 10, 0);
        checks++; if (mismatch_a !== 1'b0 || locked_a !== 1'b0) begin failures++; $display("FAIL err_resync mm=%0b locked=%0b exp=0,0", mismatch_a, locked_a); end
        tick(1, 11, 0);
        checks++; if (locked_a !== 1'b1) begin failures++; $display("FAIL err_relock got=%0b exp=1", locked_a); end
    endtask

    task automatic test_wrap();
        for (int c = 12; c <= 15; c++) begin
            tick(1, c, 0);
            checks++; if (wrap_a !== 1'b0) begin failures++; $display("FAIL wrap_early_%0d got=%0b exp=0", c, wrap_a); end
        end
        tick(1, 0, 0);
        checks++; if (wrap_a !== 1'b1 || mismatch_a !== 1'b0) begin failures++; $display("FAIL wrap_pulse wrap=%0b mm=%0b exp=1,0", wrap_a, mismatch_a); end
        tick(1, 1, 0);
        checks++; if (wrap_a !== 1'b0) begin failures++; $display("FAIL wrap_one_cycle got=%0b exp=0", wrap_a); end
    endtask

    task automatic inject_and_relock(input bit clr, output int pulses);
        pulses = 0;
        tick(1, m_expected() ^ 8, clr);
        pulses += int'(mismatch_a);
        repeat (2) begin
            tick(1, m_expected(), 0);
            pulses += int'(mismatch_a);
        end
    endtask

    task automatic test_clear();
        int p;
        repeat (2) inject_and_relock(0, p);
        checks++; if (err_count_a !== 8'd3) begin failures++; $display("FAIL clear_pre got=%0d exp=3", err_count_a); end
        tick(1, m_expected() ^ 8, 1);
        checks++; if (err_count_a !== 8'd1 || err_flag_a !== 1'b1 || err_count_b !== 2'd1) begin failures++; $display("FAIL clear_vs_error a=%0d flag=%0b b=%0d exp=1,1,1", err_count_a, err_flag_a, err_count_b); end
        repeat (2) tick(1, m_expected(), 0);
        tick(1, m_expected(), 1);
        checks++; if (err_count_a !== 8'd0 || err_flag_a !== 1'b0 || locked_a !== 1'b1) begin failures++; $display("FAIL clear_alone cnt=%0d flag=%0b locked=%0b exp=0,0,1", err_count_a, err_flag_a, locked_a); end
    endtask

    task automatic test_saturation();
        int p, total;
        total = 0;
        repeat (5) begin
            inject_and_relock(0, p);
            total += p;
        end
        checks++; if (total !== 5) begin failures++; $display("FAIL sat_pulses got=%0d exp=5", total); end
        checks++; if (err_count_b !== 2'd3 || err_flag_b !== 1'b1) begin failures++; $display("FAIL sat_count_b cnt=%0d flag=%0b exp=3,1", err_count_b, err_flag_b); end
        checks++; if (err_count_a !== 8'd5) begin failures++; $display("FAIL sat_count_a got=%0d exp=5", err_count_a); end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++; if ({locked_a, err_flag_a, err_count_a, expected_a} !== 14'd0) begin failures++; $display("FAIL async_reset_a got=%b exp=0", {locked_a, err_flag_a, err_count_a, expected_a}); end
        checks++; if ({locked_b, err_flag_b, err_count_b} !== 4'd0) begin failures++; $display("FAIL async_reset_b got=%b exp=0", {locked_b, err_flag_b, err_count_b}); end
        @(negedge clk);
        rst = 1'b0;
        tick(1, 7, 0);
        tick(1, 8, 0);
        checks++; if (locked_a !== 1'b0) begin failures++; $display("FAIL relock_early got=%0b exp=0", locked_a); end
        tick(1, 9, 0);
        checks++; if (locked_a !== 1'b1) begin failures++; $display("FAIL relock got=%0b exp=1", locked_a); end
    endtask

    task automatic test_random();
        bit en, clr;
        int c;
        for (int i = 0; i < 400; i++) begin
            en  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 9) == 0);
            c   = m_expected();
            if ($urandom_range(0, 7) == 0) c = (c ^ int'($urandom_range(1, 15))) & 15;
            tick(en, c, clr);
            checks++; if (locked_a !== m_locked || locked_b !== m_locked) begin failures++; $display("FAIL rnd_locked_%0d a=%0b b=%0b exp=%0b", i, locked_a, locked_b, m_locked); end
            checks++; if (mismatch_a !== m_mm || mismatch_b !== m_mm) begin failures++; $display("FAIL rnd_mismatch_%0d a=%0b b=%0b exp=%0b", i, mismatch_a, mismatch_b, m_mm); end
            checks++; if (wrap_a !== m_wrap || wrap_b !== m_wrap) begin failures++; $display("FAIL rnd_wrap_%0d a=%0b b=%0b exp=%0b", i, wrap_a, wrap_b, m_wrap); end
            checks++; if (err_flag_a !== m_flag || err_flag_b !== m_flag) begin failures++; $display("FAIL rnd_flag_%0d a=%0b b=%0b exp=%0b", i, err_flag_a, err_flag_b, m_flag); end
            checks++; if (int'(err_count_a) !== sat(m_errors, 255)) begin failures++; $display("FAIL rnd_count_a_%0d got=%0d exp=%0d", i, err_count_a, sat(m_errors, 255)); end
            checks++; if (int'(err_count_b) !== sat(m_errors, 3)) begin failures++; $display("FAIL rnd_count_b_%0d got=%0d exp=%0d", i, err_count_b, sat(m_errors, 3)); end
            checks++; if (int'(expected_a) !== m_expected() || int'(expected_b) !== m_expected()) begin failures++; $display("FAIL rnd_expected_%0d a=%0d b=%0d exp=%0d", i, expected_a, expected_b, m_expected()); end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_hold();
        test_error();
        test_wrap();
        test_clear();
        test_saturation();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
